// File: rtl/pow_5_root_seq.sv
// Purpose : sequential integer fifth root, root = floor(n^(1/5)), found by an MSB-first
//           binary search. Each trial candidate is raised to the 5th power on one shared
//           multiplier and then compared against the sampled radicand.
// Latency : 6 cycles per root bit. ready pulses in cycle 6*ROOT_W+1 after the run edge.
//           This is 25 cycles for the defaults and does not depend on n.
// Backpressure: none. run restarts the block from any state, and the newest run wins.
// Ports   : clock/reset (async, active-high); run + n start a job, and n is sampled only
//           on the run edge; busy is high during the search; ready is a one-cycle result
//           strobe; root is the result, held until the next run.
module pow_5_root_seq #(
    parameter int WIDTH  = 18,
    parameter int ROOT_W = (WIDTH + 4) / 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [WIDTH-1:0]  n,
    output logic              busy,
    output logic              ready,
    output logic [ROOT_W-1:0] root
);

    // Width of cand^5. It cannot overflow, because cand < 2^ROOT_W.
    localparam int ACC_W = 5 * ROOT_W;
    localparam int BIT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TRY,
        MUL,
        CMP,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   n_r;
    logic [ACC_W-1:0]   acc;
    logic [ROOT_W-1:0]  cand;
    logic [BIT_W-1:0]   bit_idx;
    logic [1:0]         mcnt;
    logic [ROOT_W-1:0]  trial;

    // Candidate for this step: the bits accepted so far, plus the bit under test.
    assign trial = root | (ROOT_W'(1) << bit_idx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            n_r     <= '0;
            acc     <= '0;
            cand    <= '0;
            bit_idx <= '0;
            mcnt    <= '0;
            root    <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (run) begin
                // A restart overrides every other transition, including DONE.
                n_r     <= n;
                root    <= '0;
                bit_idx <= BIT_W'(ROOT_W - 1);
                state   <= TRY;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    TRY: begin
                        cand  <= trial;
                        acc   <= ACC_W'(trial);
                        mcnt  <= '0;
                        state <= MUL;
                        busy  <= 1'b1;
                    end
                    MUL: begin
                        // The accumulator starts at cand, so four passes leave cand^5 in it.
                        acc  <= acc * ACC_W'(cand);
                        mcnt <= mcnt + 2'd1;
                        if (mcnt == 2'd3) begin
                            state <= CMP;
                        end
                        busy <= 1'b1;
                    end
                    CMP: begin
                        if (acc <= ACC_W'(n_r)) begin
                            root <= cand;
                        end
                        if (bit_idx == '0) begin
                            // busy and ready are registered with the state they decode.
                            state <= DONE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx - BIT_W'(1);
                            state   <= TRY;
                            busy    <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
